// File: rtl/wb_burst_pkg.sv
// Shared types for the Wishbone burst master: opcodes, response status,
// FSM states and the transaction record used on the transactor side.
package wb_burst_pkg;

  localparam int TIMEOUT_DEFAULT = 4000;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_IDLE  = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_ERR     = 2'd1,
    STAT_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_BUS,
    S_RESP,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    op_e         op;
    logic [3:0]  len;
  } txn_t;

  // Opcode 3 is reserved and behaves like IDLE.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'd0:    return OP_WRITE;
      2'd1:    return OP_READ;
      default: return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wb_burst_master_tmo.sv
// Strobe watchdog: counts cycles with run high; expired marks the last
// permitted cycle so an ack arriving in that same cycle still wins.
module wb_timeout_ctr
  import wb_burst_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone classic burst master. States: IDLE wait req | WDATA fetch write
// beat | BUS stb high | RESP hold response | DRAIN drop unused write beats.
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST   = 16,
  parameter int ADDR_STEP   = 1,
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [$clog2(MAX_BURST)-1:0] req_len,
  input  logic                         wd_valid,
  output logic                         wd_ready,
  input  logic [DATA_W-1:0]            wd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [1:0]                   rsp_status,
  output logic                         rsp_last,
  output logic                         wb_cyc,
  output logic                         wb_stb,
  output logic                         wb_we,
  output logic [ADDR_W-1:0]            wb_adr,
  output logic [DATA_W-1:0]            wb_dat_o,
  output logic [DATA_W/8-1:0]          wb_sel,
  input  logic [DATA_W-1:0]            wb_dat_i,
  input  logic                         wb_ack,
  input  logic                         wb_err
);

  localparam int LEN_W = $clog2(MAX_BURST);

  state_e              state_q, state_d;
  op_e                 op_q, op_d, req_op_e;
  status_e             status_q, status_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d, beat_q, beat_d, beat_nx;
  logic [DATA_W-1:0]   wdat_q, wdat_d, rdat_q, rdat_d;
  logic                last_q, last_d, abort_q, abort_d, cyc_q, cyc_d;
  logic                beat_final, bus_active, tmo_clear, expired;

  assign req_op_e   = decode_op(req_op);
  assign beat_final = (beat_q == len_q);
  assign beat_nx    = beat_q + LEN_W'(1);
  assign bus_active = (state_q == S_BUS);
  assign tmo_clear  = !bus_active;

  wb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (bus_active),
    .clear   (tmo_clear),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_WRITE;
      status_q <= STAT_OK;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      last_q   <= 1'b0;
      abort_q  <= 1'b0;
      cyc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      last_q   <= last_d;
      abort_q  <= abort_d;
      cyc_q    <= cyc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    status_d = status_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    last_d   = last_q;
    abort_d  = abort_q;
    cyc_d    = cyc_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        op_d     = req_op_e;
        addr_d   = req_addr;
        len_d    = req_len;
        beat_d   = '0;
        rdat_d   = '0;
        status_d = STAT_OK;
        last_d   = 1'b0;
        abort_d  = 1'b0;
        cyc_d    = 1'b0;
        case (req_op_e)
          OP_WRITE: state_d = S_WDATA;
          OP_READ:  state_d = S_BUS;
          default: begin
            state_d = S_RESP;
            last_d  = 1'b1;
          end
        endcase
      end
      S_WDATA: if (wd_valid) begin
        wdat_d  = wd_data;
        state_d = S_BUS;
      end
      S_BUS: begin
        if (wb_err) begin
          status_d = STAT_ERR;
          rdat_d   = '0;
          last_d   = 1'b1;
          abort_d  = 1'b1;
          cyc_d    = 1'b0;
          state_d  = S_RESP;
        end else if (wb_ack) begin
          status_d = STAT_OK;
          rdat_d   = (op_q == OP_READ) ? wb_dat_i : '0;
          last_d   = beat_final;
          cyc_d    = !beat_final;
          state_d  = S_RESP;
        end else if (expired) begin
          status_d = STAT_TIMEOUT;
          rdat_d   = '0;
          last_d   = 1'b1;
          abort_d  = 1'b1;
          cyc_d    = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_RESP: if (rsp_ready) begin
        if (!last_q) begin
          addr_d  = addr_q + ADDR_W'(ADDR_STEP);
          beat_d  = beat_nx;
          state_d = (op_q == OP_WRITE) ? S_WDATA : S_BUS;
        end else if (abort_q && (op_q == OP_WRITE) && !beat_final) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      // beat_q walks up to len_q so the wd stream loses exactly the unused beats.
      S_DRAIN: if (wd_valid) begin
        beat_d = beat_nx;
        if (beat_nx == len_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    wd_ready   = (state_q == S_WDATA) || (state_q == S_DRAIN);
    rsp_valid  = (state_q == S_RESP);
    rsp_data   = rdat_q;
    rsp_status = status_q;
    rsp_last   = last_q;
    wb_stb     = bus_active;
    wb_cyc     = bus_active || cyc_q;
    wb_we      = bus_active && (op_q == OP_WRITE);
    wb_adr     = addr_q;
    wb_dat_o   = wdat_q;
    wb_sel     = '1;
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a scripted Wishbone slave and a
// write-data feeder; timeout shortened to 8 cycles.
module tb_wb_burst_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MB  = 16;
  localparam int LW  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wd_valid = 1'b0;
  logic          wd_ready;
  logic [DW-1:0] wd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          rsp_last;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack = 1'b0;
  logic          wb_err = 1'b0;

  int errors = 0;
  int checks = 0;

  // slave script: ack/err in the ack_at-th stb cycle (0 = never), err on beat err_beat
  int          ack_at = 1;
  int          err_beat = 0;
  logic [31:0] rd_base = '0;

  int   stb_total = 0, stb_rises = 0, cyc_rises = 0, stb_run = 0, beat_idx = 0, rsp_n = 0;
  logic prev_stb = 1'b0, prev_cyc = 1'b0;
  logic [31:0] bus_adr[$];
  logic [31:0] bus_dat[$];
  logic        bus_we[$];
  logic [31:0] rsp_dq[$];
  logic [1:0]  rsp_sq[$];
  logic        rsp_lq[$];

  logic [31:0] wd_mem[64];
  int          wd_wr = 0;
  int          wd_rd = 0;

  wb_burst_master #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .ADDR_STEP(1), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_last(rsp_last),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_stb) begin
      stb_total++;
      if (!prev_stb) stb_rises++;
      stb_run++;
      wb_err   = (ack_at != 0) && (stb_run == ack_at) && (err_beat == beat_idx + 1);
      wb_ack   = (ack_at != 0) && (stb_run == ack_at) && !wb_err;
      wb_dat_i = rd_base + beat_idx;
      if (wb_ack || wb_err) begin
        bus_adr.push_back(wb_adr);
        bus_dat.push_back(wb_dat_o);
        bus_we.push_back(wb_we);
        beat_idx++;
      end
    end else begin
      stb_run = 0;
      wb_ack  = 1'b0;
      wb_err  = 1'b0;
    end
    if (wb_cyc && !prev_cyc) cyc_rises++;
    if (!wb_cyc) beat_idx = 0;
    prev_stb = wb_stb;
    prev_cyc = wb_cyc;
    if (rsp_valid && rsp_ready) begin
      rsp_dq.push_back(rsp_data);
      rsp_sq.push_back(rsp_status);
      rsp_lq.push_back(rsp_last);
      rsp_n++;
    end
  end

  always begin : feeder
    bit pop;
    @(negedge clk);
    pop = wd_valid && wd_ready && rst_n;
    @(posedge clk);
    #1;
    if (pop) wd_rd++;
    wd_valid = (wd_rd != wd_wr);
    wd_data  = wd_mem[wd_rd % 64];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wd(input logic [31:0] v);
    wd_mem[wd_wr % 64] = v;
    wd_wr++;
  endtask

  task automatic send_req(input logic [1:0] op, input logic [31:0] addr, input logic [3:0] len);
    bit hs;
    hs = 1'b0;
    req_op = op; req_addr = addr; req_len = len; req_valid = 1'b1;
    for (int k = 0; k < 50 && !hs; k++) begin
      @(negedge clk);
      hs = req_ready;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (hs !== 1'b1) begin
      errors++;
      $display("FAIL req_handshake: req_ready=%0b required 1 within 50 cycles", hs);
    end
  endtask

  task automatic wait_rsp(input int target, input string nm);
    int k;
    k = 0;
    while (rsp_n < target && k < 200) begin
      tick(1);
      k++;
    end
    checks++;
    if (rsp_n < target) begin
      errors++;
      $display("FAIL %s_wait: responses=%0d required %0d", nm, rsp_n, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({wb_cyc, wb_stb, wb_we, rsp_valid, rsp_last, wd_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cyc/stb/we/rv/last/wdr=%b required 000000",
               {wb_cyc, wb_stb, wb_we, rsp_valid, rsp_last, wd_ready});
    end
    checks++;
    if (wb_adr !== 32'h0 || wb_dat_o !== 32'h0 || rsp_data !== 32'h0 || rsp_status !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: adr=%h dat_o=%h rdata=%h status=%0d required all 0",
               wb_adr, wb_dat_o, rsp_data, rsp_status);
    end
    checks++;
    if (wb_sel !== 4'hF) begin
      errors++;
      $display("FAIL reset_sel: wb_sel=%h required f", wb_sel);
    end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready: req_ready=%0b required 1", req_ready);
    end
  endtask

  task automatic test_read_single();
    int r0, b0, s0;
    r0 = rsp_n; b0 = bus_adr.size(); s0 = stb_total;
    ack_at = 3; err_beat = 0; rd_base = 32'hDEADBEEF; rsp_ready = 1'b1;
    send_req(2'd1, 32'h10, 4'd0);
    checks++;
    if (wb_stb !== 1'b1) begin
      errors++;
      $display("FAIL read_latency: wb_stb=%0b one cycle after handshake, required 1", wb_stb);
    end
    wait_rsp(r0 + 1, "read_single");
    tick(3);
    checks++;
    if (rsp_n - r0 != 1 || rsp_dq[r0] !== 32'hDEADBEEF || rsp_sq[r0] !== 2'd0 || rsp_lq[r0] !== 1'b1) begin
      errors++;
      $display("FAIL read_single_rsp: n=%0d data=%h status=%0d last=%0b required 1 deadbeef 0 1",
               rsp_n - r0, rsp_dq[r0], rsp_sq[r0], rsp_lq[r0]);
    end
    checks++;
    if (stb_total - s0 != 3) begin
      errors++;
      $display("FAIL read_single_stb: stb cycles=%0d required 3", stb_total - s0);
    end
    checks++;
    if (bus_adr[b0] !== 32'h10 || bus_we[b0] !== 1'b0) begin
      errors++;
      $display("FAIL read_single_bus: adr=%h we=%0b required 10 0", bus_adr[b0], bus_we[b0]);
    end
  endtask

  task automatic test_write_burst();
    int r0, b0, c0;
    logic [31:0] ea[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    r0 = rsp_n; b0 = bus_adr.size(); c0 = cyc_rises;
    for (int i = 1; i <= 4; i++) push_wd(32'(i));
    ack_at = 1; err_beat = 0;
    send_req(2'd0, 32'hFFFFFFFE, 4'd3);
    wait_rsp(r0 + 4, "write_burst");
    tick(3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus_adr[b0+i] !== ea[i] || bus_dat[b0+i] !== 32'(i + 1) || bus_we[b0+i] !== 1'b1) begin
        errors++;
        $display("FAIL write_burst_beat%0d: adr=%h dat=%h we=%0b required %h %h 1",
                 i, bus_adr[b0+i], bus_dat[b0+i], bus_we[b0+i], ea[i], 32'(i + 1));
      end
      checks++;
      if (rsp_sq[r0+i] !== 2'd0 || rsp_lq[r0+i] !== (i == 3) || rsp_dq[r0+i] !== 32'h0) begin
        errors++;
        $display("FAIL write_burst_rsp%0d: status=%0d last=%0b data=%h required 0 %0b 0",
                 i, rsp_sq[r0+i], rsp_lq[r0+i], rsp_dq[r0+i], (i == 3));
      end
    end
    checks++;
    if (cyc_rises - c0 != 1 || rsp_n - r0 != 4) begin
      errors++;
      $display("FAIL write_burst_cyc: cyc rises=%0d responses=%0d required 1 4",
               cyc_rises - c0, rsp_n - r0);
    end
  endtask

  task automatic test_read_err();
    int r0, b0, s0;
    r0 = rsp_n; b0 = bus_adr.size(); s0 = stb_rises;
    ack_at = 1; err_beat = 2; rd_base = 32'h100;
    send_req(2'd1, 32'h40, 4'd3);
    wait_rsp(r0 + 2, "read_err");
    tick(4);
    checks++;
    if (rsp_dq[r0] !== 32'h100 || rsp_sq[r0] !== 2'd0 || rsp_lq[r0] !== 1'b0) begin
      errors++;
      $display("FAIL read_err_beat1: data=%h status=%0d last=%0b required 100 0 0",
               rsp_dq[r0], rsp_sq[r0], rsp_lq[r0]);
    end
    checks++;
    if (rsp_sq[r0+1] !== 2'd1 || rsp_lq[r0+1] !== 1'b1 || bus_adr[b0+1] !== 32'h41) begin
      errors++;
      $display("FAIL read_err_beat2: status=%0d last=%0b adr=%h required 1 1 41",
               rsp_sq[r0+1], rsp_lq[r0+1], bus_adr[b0+1]);
    end
    checks++;
    if (stb_rises - s0 != 2 || rsp_n - r0 != 2 || wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL read_err_abort: stb rises=%0d responses=%0d cyc=%0b required 2 2 0",
               stb_rises - s0, rsp_n - r0, wb_cyc);
    end
    err_beat = 0;
  endtask

  task automatic test_write_drain();
    int r0, w0, b1;
    r0 = rsp_n; w0 = wd_rd;
    push_wd(32'h11); push_wd(32'h22); push_wd(32'h33); push_wd(32'h44); push_wd(32'h55);
    ack_at = 1; err_beat = 1;
    send_req(2'd0, 32'h200, 4'd3);
    wait_rsp(r0 + 1, "write_drain");
    tick(8);
    checks++;
    if (rsp_n - r0 != 1 || rsp_sq[r0] !== 2'd1 || rsp_lq[r0] !== 1'b1) begin
      errors++;
      $display("FAIL write_drain_rsp: responses=%0d status=%0d last=%0b required 1 1 1",
               rsp_n - r0, rsp_sq[r0], rsp_lq[r0]);
    end
    checks++;
    if (wd_rd - w0 != 4 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_drain_count: wd consumed=%0d req_ready=%0b required 4 1",
               wd_rd - w0, req_ready);
    end
    err_beat = 0;
    b1 = bus_dat.size();
    send_req(2'd0, 32'h300, 4'd0);
    wait_rsp(r0 + 2, "write_after_drain");
    tick(3);
    checks++;
    if (bus_dat[b1] !== 32'h55 || bus_adr[b1] !== 32'h300 || rsp_sq[r0+1] !== 2'd0) begin
      errors++;
      $display("FAIL write_after_drain: dat=%h adr=%h status=%0d required 55 300 0",
               bus_dat[b1], bus_adr[b1], rsp_sq[r0+1]);
    end
  endtask

  task automatic test_timeout();
    int r0, s0, s1;
    r0 = rsp_n; s0 = stb_total;
    ack_at = 0;
    send_req(2'd1, 32'h500, 4'd1);
    wait_rsp(r0 + 1, "timeout");
    tick(3);
    checks++;
    if (stb_total - s0 != TMO || rsp_n - r0 != 1) begin
      errors++;
      $display("FAIL timeout_stb: stb cycles=%0d responses=%0d required %0d 1",
               stb_total - s0, rsp_n - r0, TMO);
    end
    checks++;
    if (rsp_sq[r0] !== 2'd2 || rsp_lq[r0] !== 1'b1 || wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rsp: status=%0d last=%0b cyc=%0b required 2 1 0",
               rsp_sq[r0], rsp_lq[r0], wb_cyc);
    end
    s1 = stb_total;
    ack_at = TMO; rd_base = 32'h5A5A0000;
    send_req(2'd1, 32'h510, 4'd0);
    wait_rsp(r0 + 2, "timeout_edge");
    tick(3);
    checks++;
    if (stb_total - s1 != TMO || rsp_sq[r0+1] !== 2'd0 || rsp_dq[r0+1] !== 32'h5A5A0000) begin
      errors++;
      $display("FAIL timeout_edge_ack: stb cycles=%0d status=%0d data=%h required %0d 0 5a5a0000",
               stb_total - s1, rsp_sq[r0+1], rsp_dq[r0+1], TMO);
    end
  endtask

  task automatic test_stall_reset();
    int k, n0;
    ack_at = 1; rd_base = 32'h700; rsp_ready = 1'b0;
    send_req(2'd1, 32'h600, 4'd3);
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick(1);
      k++;
    end
    ack_at = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h700 || rsp_status !== 2'd0 ||
          rsp_last !== 1'b0 || wb_cyc !== 1'b1 || wb_stb !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: rv=%0b data=%h st=%0d last=%0b cyc=%0b stb=%0b required 1 700 0 0 1 0",
                 i, rsp_valid, rsp_data, rsp_status, rsp_last, wb_cyc, wb_stb);
      end
      tick(1);
    end
    rsp_ready = 1'b1;
    tick(3);
    checks++;
    if (wb_stb !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume: wb_stb=%0b required 1", wb_stb);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cyc=%0b stb=%0b required 0 0", wb_cyc, wb_stb);
    end
    tick(2);
    checks++;
    if ({wb_cyc, wb_stb, wb_we, rsp_valid, rsp_last, wd_ready} !== 6'b0 ||
        rsp_data !== 32'h0 || wb_adr !== 32'h0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midburst_reset_state: ctrl=%b rdata=%h adr=%h req_ready=%0b required 000000 0 0 1",
               {wb_cyc, wb_stb, wb_we, rsp_valid, rsp_last, wd_ready}, rsp_data, wb_adr, req_ready);
    end
    rst_n = 1'b1;
    n0 = rsp_n;
    tick(5);
    checks++;
    if (rsp_n != n0 || rsp_valid !== 1'b0 || wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: new responses=%0d rv=%0b cyc=%0b required 0 0 0",
               rsp_n - n0, rsp_valid, wb_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_write_burst();
    test_read_err();
    test_write_drain();
    test_timeout();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Synthesizable Wishbone classic master that executes queued WRITE/READ/IDLE transactions, with incrementing bursts and a hardware timeout.
- Sits between the IPbus-side transactor, which supplies the request and write-data streams and takes the response stream, and a Wishbone slave fabric.
- Generalises the bench-only transaction model: data and address widths, burst length, address step and timeout are parameters; error and timeout are reported per beat.

Parameters:
ADDR_W, 32, Wishbone address width
DATA_W, 32, Wishbone data width (multiple of 8)
MAX_BURST, 16, maximum beats per request (power of 2)
ADDR_STEP, 1, address increment per beat
TIMEOUT_CYC, 4000, maximum cycles stb may stay high without ack/err (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  2  0=WRITE 1=READ 2=IDLE (3 treated as IDLE)
req_addr  in  ADDR_W  first-beat address
req_len  in  $clog2(MAX_BURST)  beats minus one
wd_valid  in  1  write-data valid
wd_ready  out  1  write-data accepted
wd_data  in  DATA_W  write beat data
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_data  out  DATA_W  read data (0 for WRITE/IDLE)
rsp_status  out  2  0=OK 1=ERR 2=TIMEOUT
rsp_last  out  1  final response of the request
wb_cyc, wb_stb, wb_we  out  1 each  Wishbone cycle, strobe, write enable
wb_adr  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_sel  out  DATA_W/8  byte selects, always all ones
wb_dat_i  in  DATA_W  Wishbone read data
wb_ack, wb_err  in  1 each  slave acknowledge, error

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, except wb_sel, which is all ones. FSM returns to IDLE. Beat counter and timeout counter are cleared.
- Reset mid-burst: cyc and stb drop asynchronously. No response is generated.
- States: IDLE, WDATA, BUS, RESP, DRAIN.
- IDLE:
  - req_ready=1; captures op, addr and len on handshake.
  - READ goes to BUS.
  - WRITE goes to WDATA.
  - IDLE op goes to RESP with status OK, last=1, no bus activity.
- WDATA: wd_ready=1. On wd handshake, data is latched into wb_dat_o and the FSM goes to BUS in the next cycle.
- BUS:
  - cyc=stb=1, we=(op==WRITE).
  - cyc stays high across all beats of a burst; stb drops for at least one cycle between beats.
  - Read latency: request handshake at edge N, stb first high in cycle N+1.
  - ack sampled at edge M: stb drops after M, rsp_valid is high in cycle M+1 with wb_dat_i captured at M, status OK.
  - Priority: err over ack. An err gives status ERR; remaining beats are aborted and rsp_last=1.
  - Timeout: counter increments each cycle stb is high. If TIMEOUT_CYC cycles pass without ack/err, cyc and stb drop, status is TIMEOUT, rsp_last=1, remaining beats are aborted.
  - An ack in the same cycle the count expires wins; the beat is OK.
- RESP:
  - rsp_* is held stable until rsp_ready. cyc stays high during RESP unless the response is final or aborting.
  - On handshake, if more beats remain: address += ADDR_STEP (wraps modulo 2^ADDR_W), then go to WDATA (write) or BUS (read).
  - Otherwise go to DRAIN (aborted write with beats left) or IDLE.
- DRAIN: wd_ready=1; discards the remaining unconsumed write beats so the wd stream stays aligned to requests, then goes to IDLE.
- wb_ack/wb_err while stb=0 are ignored.
- rsp_last=1 on beat req_len, or on an aborting beat.
- Throughput: at most one request outstanding; no pipelined Wishbone.

Decomposition:
- Package wb_burst_pkg holds:
  - op enum {WRITE=0, READ=1, IDLE=2}
  - status enum {OK=0, ERR=1, TIMEOUT=2}
  - state enum
  - transaction struct (addr, data, op, len)
  - default TIMEOUT constant 4000
- One sub-module, wb_timeout_ctr: TIMEOUT_CYC parameter, inputs clk/rst_n/run/clear, output expired; $clog2(TIMEOUT_CYC+1)-bit counter.

Test Plan:
- Single READ addr=0x10, len=0; slave acks 2 cycles after stb with 0xDEADBEEF -> one response, data=0xDEADBEEF, status OK, last=1; stb high exactly 3 cycles.
- WRITE burst addr=0xFFFFFFFE, len=3, wd=1,2,3,4 -> bus writes to FFFFFFFE, FFFFFFFF, 00000000, 00000001 with data 1..4; 4 OK responses, last only on the 4th; cyc continuous.
- READ burst len=3 with err on beat 2 -> 2 responses: OK, then ERR with last=1; no third stb; cyc low after.
- WRITE len=3 with err on beat 1 -> ERR/last response; DRAIN consumes 3 more wd words; the next WRITE uses the 5th wd word.
- TIMEOUT_CYC=8, slave never acks -> stb high exactly 8 cycles, then rsp TIMEOUT with last=1. Also ack on the 8th cycle -> OK.
- rsp_ready held low 5 cycles during a burst, then rst_n pulsed mid-BUS -> rsp stable while stalled; after reset all outputs 0, req_ready=1.
